// File: rtl/gs_ddram_pkg.sv
// rtl/gs_ddram_pkg.sv - shared types and constants for the GS DDR3 arbiter
//
// Purpose : FSM state and port-select enums, fixed Avalon constants and a
//           byte-lane extraction helper used by the arbiter and its caches.
// Contents: state_e (IDLE, ISSUE, RD_WAIT, DONE), port_e (PORT_A, PORT_B),
//           BURST_ONE, BE_ALL, byte_sel(line, off).
package gs_ddram_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RD_WAIT = 2'd2,
      DONE    = 2'd3
   } state_e;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;

   localparam logic [7:0] BURST_ONE = 8'd1;
   localparam logic [7:0] BE_ALL    = 8'hFF;

   // Byte lane 'off' of a 64-bit little-endian DDR3 word.
   function automatic logic [7:0] byte_sel(input logic [63:0] line, input logic [2:0] off);
      return line[{off, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/gs_line_cache.sv
// rtl/gs_line_cache.sv - one-line (8-byte) read cache for one requester port
//
// Purpose : holds a single tagged 64-bit DDR3 word. Reports a hit for the
//           lookup tag, accepts a full-line fill, and patches one byte when a
//           write with a matching tag is granted (write-through coherency).
// Ports   : clk_i, rst_ni        clock, asynchronous active-low reset (invalidates)
//           lookup_tag_i, hit_o  hit compare for the requester's current address
//           line_o               cached 64-bit line
//           fill_i, fill_tag_i, fill_line_i   load a new line and mark valid
//           upd_i, upd_tag_i, upd_off_i, upd_byte_i   byte update on tag match
module gs_line_cache
   import gs_ddram_pkg::*;
#(
   parameter int TAG_W = 19
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [TAG_W-1:0] lookup_tag_i,
   output logic             hit_o,
   output logic [63:0]      line_o,
   input  logic             fill_i,
   input  logic [TAG_W-1:0] fill_tag_i,
   input  logic [63:0]      fill_line_i,
   input  logic             upd_i,
   input  logic [TAG_W-1:0] upd_tag_i,
   input  logic [2:0]       upd_off_i,
   input  logic [7:0]       upd_byte_i
);

   logic             valid_q, valid_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [63:0]      line_q, line_d;

   assign hit_o  = valid_q && (tag_q == lookup_tag_i);
   assign line_o = line_q;

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      line_d  = line_q;
      if (fill_i) begin
         valid_d = 1'b1;
         tag_d   = fill_tag_i;
         line_d  = fill_line_i;
      end else if (upd_i && valid_q && (tag_q == upd_tag_i)) begin
         line_d[{upd_off_i, 3'b000} +: 8] = upd_byte_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         line_q  <= '0;
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         line_q  <= line_d;
      end
   end

endmodule

// File: rtl/gs_ddram_arbiter.sv
// rtl/gs_ddram_arbiter.sv - two-port byte requester arbiter onto one DDR3 Avalon port
//
// Purpose : shares the DDR3 Avalon port between port A (General Sound memory)
//           and port B (DMA loader). Byte accesses become single-beat 64-bit
//           transactions with byte enables; round-robin between contending ports.
// Build   : GS_DDRAM_CACHE_EN defined -> per-port one-line read cache with a
//           same-cycle hit path and write-through coherency. Undefined -> every
//           read goes to DDR3 and dout comes straight from DDRAM_DOUT.
// Ports   : clk_mem, reset_n              memory clock, async active-low reset
//           a_/b_addr, _din, _rd, _wr     byte requests (level, held until ready)
//           a_/b_dout, _ready             read data, one-cycle completion pulse
//           DDRAM_*                       Avalon master towards the DDR3 controller
module gs_ddram_arbiter
   import gs_ddram_pkg::*;
#(
   parameter int          ADDR_W    = 22,
   parameter logic [28:0] BASE_ADDR = 29'h0300000
) (
   input  logic              clk_mem,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [7:0]        a_din,
   input  logic              a_rd,
   input  logic              a_wr,
   output logic [7:0]        a_dout,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [7:0]        b_din,
   input  logic              b_rd,
   input  logic              b_wr,
   output logic [7:0]        b_dout,
   output logic              b_ready,
   input  logic              DDRAM_BUSY,
   output logic [7:0]        DDRAM_BURSTCNT,
   output logic [28:0]       DDRAM_ADDR,
   input  logic [63:0]       DDRAM_DOUT,
   input  logic              DDRAM_DOUT_READY,
   output logic              DDRAM_RD,
   output logic [63:0]       DDRAM_DIN,
   output logic [7:0]        DDRAM_BE,
   output logic              DDRAM_WE
);

   localparam int TAG_W = ADDR_W - 3;

   state_e      state_q, state_d;
   port_e       rr_q, rr_d;
   port_e       gnt_q, gnt_d;
   logic        op_wr_q, op_wr_d;
   logic [2:0]  off_q, off_d;
   logic        ddr_rd_q, ddr_rd_d;
   logic        ddr_we_q, ddr_we_d;
   logic [28:0] ddr_addr_q, ddr_addr_d;
   logic [7:0]  ddr_be_q, ddr_be_d;
   logic [63:0] ddr_din_q, ddr_din_d;
   logic        a_ready_q, a_ready_d, b_ready_q, b_ready_d;
   logic [7:0]  a_dout_q, a_dout_d, b_dout_q, b_dout_d;

   logic              a_cache_hit, b_cache_hit;
   logic [63:0]       a_line, b_line;
   logic              a_rd_req, b_rd_req;
   logic              a_hit, b_hit, a_need, b_need;
   logic              grant;
   port_e             sel;
   logic [ADDR_W-1:0] sel_addr;
   logic [7:0]        sel_din;
   logic              sel_wr;

   // Write wins over a simultaneous read. A port whose ready is high this cycle
   // is ignored: its level request is still up but already served.
   assign a_rd_req = a_rd & ~a_wr;
   assign b_rd_req = b_rd & ~b_wr;
   assign a_hit    = a_rd_req & a_cache_hit & ~a_ready_q;
   assign b_hit    = b_rd_req & b_cache_hit & ~b_ready_q;
   assign a_need   = ~a_ready_q & (a_wr | (a_rd_req & ~a_cache_hit));
   assign b_need   = ~b_ready_q & (b_wr | (b_rd_req & ~b_cache_hit));

   // On contention the port not matching the round-robin pointer wins.
   always_comb begin
      sel = PORT_A;
      if (a_need && b_need) begin
         sel = (rr_q == PORT_A) ? PORT_B : PORT_A;
      end else if (b_need) begin
         sel = PORT_B;
      end
   end

   assign sel_addr = (sel == PORT_B) ? b_addr : a_addr;
   assign sel_din  = (sel == PORT_B) ? b_din  : a_din;
   assign sel_wr   = (sel == PORT_B) ? b_wr   : a_wr;

`ifdef GS_DDRAM_CACHE_EN
   logic             fill_a, fill_b;
   logic [TAG_W-1:0] tag_q;

   assign fill_a = (state_q == RD_WAIT) && DDRAM_DOUT_READY && (gnt_q == PORT_A);
   assign fill_b = (state_q == RD_WAIT) && DDRAM_DOUT_READY && (gnt_q == PORT_B);

   always_ff @(posedge clk_mem or negedge reset_n) begin
      if (!reset_n) begin
         tag_q <= '0;
      end else if (grant) begin
         tag_q <= sel_addr[ADDR_W-1:3];
      end
   end

   gs_line_cache #(.TAG_W(TAG_W)) u_cache_a (
      .clk_i        (clk_mem),
      .rst_ni       (reset_n),
      .lookup_tag_i (a_addr[ADDR_W-1:3]),
      .hit_o        (a_cache_hit),
      .line_o       (a_line),
      .fill_i       (fill_a),
      .fill_tag_i   (tag_q),
      .fill_line_i  (DDRAM_DOUT),
      .upd_i        (grant & sel_wr),
      .upd_tag_i    (sel_addr[ADDR_W-1:3]),
      .upd_off_i    (sel_addr[2:0]),
      .upd_byte_i   (sel_din)
   );

   gs_line_cache #(.TAG_W(TAG_W)) u_cache_b (
      .clk_i        (clk_mem),
      .rst_ni       (reset_n),
      .lookup_tag_i (b_addr[ADDR_W-1:3]),
      .hit_o        (b_cache_hit),
      .line_o       (b_line),
      .fill_i       (fill_b),
      .fill_tag_i   (tag_q),
      .fill_line_i  (DDRAM_DOUT),
      .upd_i        (grant & sel_wr),
      .upd_tag_i    (sel_addr[ADDR_W-1:3]),
      .upd_off_i    (sel_addr[2:0]),
      .upd_byte_i   (sel_din)
   );
`else
   assign a_cache_hit = 1'b0;
   assign b_cache_hit = 1'b0;
   assign a_line      = '0;
   assign b_line      = '0;
`endif

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      gnt_d      = gnt_q;
      op_wr_d    = op_wr_q;
      off_d      = off_q;
      ddr_rd_d   = ddr_rd_q;
      ddr_we_d   = ddr_we_q;
      ddr_addr_d = ddr_addr_q;
      ddr_be_d   = ddr_be_q;
      ddr_din_d  = ddr_din_q;
      a_ready_d  = 1'b0;
      b_ready_d  = 1'b0;
      a_dout_d   = a_dout_q;
      b_dout_d   = b_dout_q;
      grant      = 1'b0;

      case (state_q)
         IDLE: begin
            // Hits complete without consuming the DDR path.
            if (a_hit) begin
               a_ready_d = 1'b1;
               a_dout_d  = byte_sel(a_line, a_addr[2:0]);
            end
            if (b_hit) begin
               b_ready_d = 1'b1;
               b_dout_d  = byte_sel(b_line, b_addr[2:0]);
            end
            if (a_need || b_need) begin
               grant      = 1'b1;
               gnt_d      = sel;
               rr_d       = (rr_q == PORT_A) ? PORT_B : PORT_A;
               op_wr_d    = sel_wr;
               off_d      = sel_addr[2:0];
               ddr_we_d   = sel_wr;
               ddr_rd_d   = ~sel_wr;
               ddr_addr_d = BASE_ADDR + 29'(sel_addr[ADDR_W-1:3]);
               ddr_be_d   = sel_wr ? (8'h01 << sel_addr[2:0]) : BE_ALL;
               ddr_din_d  = {8{sel_din}};
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            if (!DDRAM_BUSY) begin
               ddr_rd_d = 1'b0;
               ddr_we_d = 1'b0;
               state_d  = op_wr_q ? DONE : RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (DDRAM_DOUT_READY) begin
               if (gnt_q == PORT_A) begin
                  a_dout_d = byte_sel(DDRAM_DOUT, off_q);
               end else begin
                  b_dout_d = byte_sel(DDRAM_DOUT, off_q);
               end
               state_d = DONE;
            end
         end
         DONE: begin
            if (gnt_q == PORT_A) begin
               a_ready_d = 1'b1;
            end else begin
               b_ready_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_mem or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         rr_q       <= PORT_A;
         gnt_q      <= PORT_A;
         op_wr_q    <= 1'b0;
         off_q      <= 3'd0;
         ddr_rd_q   <= 1'b0;
         ddr_we_q   <= 1'b0;
         ddr_addr_q <= '0;
         ddr_be_q   <= '0;
         ddr_din_q  <= '0;
         a_ready_q  <= 1'b0;
         b_ready_q  <= 1'b0;
         a_dout_q   <= 8'h00;
         b_dout_q   <= 8'h00;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         gnt_q      <= gnt_d;
         op_wr_q    <= op_wr_d;
         off_q      <= off_d;
         ddr_rd_q   <= ddr_rd_d;
         ddr_we_q   <= ddr_we_d;
         ddr_addr_q <= ddr_addr_d;
         ddr_be_q   <= ddr_be_d;
         ddr_din_q  <= ddr_din_d;
         a_ready_q  <= a_ready_d;
         b_ready_q  <= b_ready_d;
         a_dout_q   <= a_dout_d;
         b_dout_q   <= b_dout_d;
      end
   end

   assign DDRAM_BURSTCNT = BURST_ONE;
   assign DDRAM_ADDR     = ddr_addr_q;
   assign DDRAM_RD       = ddr_rd_q;
   assign DDRAM_WE       = ddr_we_q;
   assign DDRAM_BE       = ddr_be_q;
   assign DDRAM_DIN      = ddr_din_q;
   assign a_ready        = a_ready_q;
   assign b_ready        = b_ready_q;
   assign a_dout         = a_dout_q;
   assign b_dout         = b_dout_q;

endmodule

// File: tb/tb_gs_ddram_arbiter.sv
// tb/tb_gs_ddram_arbiter.sv - directed self-checking bench for gs_ddram_arbiter
`timescale 1ns/1ps
module tb_gs_ddram_arbiter;

`ifdef GS_DDRAM_CACHE_EN
   localparam int HIT_RDS = 0;
`else
   localparam int HIT_RDS = 1;
`endif

   logic        clk_mem = 1'b0;
   logic        reset_n = 1'b0;
   logic [21:0] a_addr = '0, b_addr = '0;
   logic [7:0]  a_din = '0, b_din = '0;
   logic        a_rd = 1'b0, a_wr = 1'b0, b_rd = 1'b0, b_wr = 1'b0;
   wire  [7:0]  a_dout, b_dout;
   wire         a_ready, b_ready;
   logic        DDRAM_BUSY;
   logic        DDRAM_DOUT_READY;
   logic [63:0] DDRAM_DOUT;
   wire  [7:0]  DDRAM_BURSTCNT;
   wire  [28:0] DDRAM_ADDR;
   wire         DDRAM_RD, DDRAM_WE;
   wire  [63:0] DDRAM_DIN;
   wire  [7:0]  DDRAM_BE;

   int n_tests = 0;
   int n_fail  = 0;

   gs_ddram_arbiter dut (
      .clk_mem          (clk_mem),
      .reset_n          (reset_n),
      .a_addr           (a_addr),
      .a_din            (a_din),
      .a_rd             (a_rd),
      .a_wr             (a_wr),
      .a_dout           (a_dout),
      .a_ready          (a_ready),
      .b_addr           (b_addr),
      .b_din            (b_din),
      .b_rd             (b_rd),
      .b_wr             (b_wr),
      .b_dout           (b_dout),
      .b_ready          (b_ready),
      .DDRAM_BUSY       (DDRAM_BUSY),
      .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
      .DDRAM_ADDR       (DDRAM_ADDR),
      .DDRAM_DOUT       (DDRAM_DOUT),
      .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
      .DDRAM_RD         (DDRAM_RD),
      .DDRAM_DIN        (DDRAM_DIN),
      .DDRAM_BE         (DDRAM_BE),
      .DDRAM_WE         (DDRAM_WE)
   );

   always #5 clk_mem = ~clk_mem;

   int cyc = 0;
   always @(posedge clk_mem) cyc <= cyc + 1;

   // DDR3 controller model: BUSY for busy_len cycles per command, read data
   // five cycles after acceptance, byte-enabled writes into a sparse memory.
   logic [63:0] mem [logic [28:0]];
   int          busy_len = 0;
   int          busy_cnt = 0, pend = 0;
   int          rd_cmds = 0, wr_cmds = 0, we_cycles = 0, last_we_cyc = 0;
   logic [28:0] last_addr = '0;
   logic [7:0]  last_be = '0;
   logic [63:0] last_din = '0, pend_data = '0;
   logic [28:0] cmd_log [$];

   function automatic logic [63:0] mem_rd(input logic [28:0] w);
      if (mem.exists(w)) return mem[w];
      return {8{w[7:0]}};
   endfunction

   initial begin : ddr_model
      logic [63:0] line;
      DDRAM_BUSY = 1'b0;
      DDRAM_DOUT_READY = 1'b0;
      DDRAM_DOUT = '0;
      mem[29'h0300002] = 64'h8877665544332211;
      forever begin
         @(negedge clk_mem);
         DDRAM_DOUT_READY = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               DDRAM_DOUT_READY = 1'b1;
               DDRAM_DOUT = pend_data;
            end
         end
         if (DDRAM_WE) begin
            we_cycles++;
            last_we_cyc = cyc;
         end
         if (DDRAM_RD || DDRAM_WE) begin
            if (busy_cnt < busy_len) begin
               DDRAM_BUSY = 1'b1;
               busy_cnt++;
            end else begin
               DDRAM_BUSY = 1'b0;
               busy_cnt = 0;
               cmd_log.push_back(DDRAM_ADDR);
               last_addr = DDRAM_ADDR;
               last_be = DDRAM_BE;
               last_din = DDRAM_DIN;
               if (DDRAM_WE) begin
                  wr_cmds++;
                  line = mem_rd(DDRAM_ADDR);
                  for (int i = 0; i < 8; i++)
                     if (DDRAM_BE[i]) line[i*8 +: 8] = DDRAM_DIN[i*8 +: 8];
                  mem[DDRAM_ADDR] = line;
               end else begin
                  rd_cmds++;
                  pend = 5;
                  pend_data = mem_rd(DDRAM_ADDR);
               end
            end
         end else begin
            DDRAM_BUSY = 1'b0;
            busy_cnt = 0;
         end
      end
   end

   task automatic tick();
      @(negedge clk_mem);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      a_rd = 0; a_wr = 0; b_rd = 0; b_wr = 0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   // Drives one request on a port, waits for ready (bounded), drops the request.
   task automatic do_req(input bit pb, input bit wr, input logic [21:0] addr,
                         input logic [7:0] din, output logic [7:0] dout,
                         output int lat, output int pulses, output int rdy_cyc);
      logic rdy;
      if (pb) begin b_addr = addr; b_din = din; b_wr = wr; b_rd = ~wr; end
      else    begin a_addr = addr; a_din = din; a_wr = wr; a_rd = ~wr; end
      lat = 0; pulses = 0; dout = '0; rdy_cyc = 0; rdy = 1'b0;
      while (!rdy && lat < 200) begin
         tick();
         lat++;
         rdy = pb ? b_ready : a_ready;
      end
      if (rdy) begin
         pulses = 1;
         rdy_cyc = cyc;
         dout = pb ? b_dout : a_dout;
      end
      a_rd = 0; a_wr = 0; b_rd = 0; b_wr = 0;
      tick();
      if (pb ? b_ready : a_ready) pulses++;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      n_tests++;
      if ({DDRAM_RD, DDRAM_WE, a_ready, b_ready} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctl: rd/we/ardy/brdy=%b expected 0000", {DDRAM_RD, DDRAM_WE, a_ready, b_ready});
      end
      n_tests++;
      if (DDRAM_ADDR !== 29'h0 || DDRAM_BE !== 8'h00 || DDRAM_DIN !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_bus: addr=%h be=%h din=%h expected all zero", DDRAM_ADDR, DDRAM_BE, DDRAM_DIN);
      end
      n_tests++;
      if (a_dout !== 8'h00 || b_dout !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_dout: a=%h b=%h expected 00 00", a_dout, b_dout);
      end
      n_tests++;
      if (DDRAM_BURSTCNT !== 8'd1) begin
         n_fail++;
         $display("FAIL burstcnt: got %h expected 01", DDRAM_BURSTCNT);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_read_miss();
      logic [7:0] d;
      int lat, p, rc, rd0;
      rd0 = rd_cmds;
      do_req(1'b0, 1'b0, 22'h000010, 8'h00, d, lat, p, rc);
      n_tests++;
      if (d !== 8'h11) begin n_fail++; $display("FAIL miss_dout: got %h expected 11", d); end
      n_tests++;
      if (p !== 1) begin n_fail++; $display("FAIL miss_pulse: got %0d pulses expected 1", p); end
      n_tests++;
      if (last_addr !== 29'h0300002 || last_be !== 8'hFF) begin
         n_fail++;
         $display("FAIL miss_cmd: addr=%h be=%h expected 0300002 ff", last_addr, last_be);
      end
      n_tests++;
      if (rd_cmds - rd0 !== 1) begin n_fail++; $display("FAIL miss_rdcnt: got %0d expected 1", rd_cmds - rd0); end
      rd0 = rd_cmds;
      do_req(1'b0, 1'b0, 22'h000013, 8'h00, d, lat, p, rc);
      n_tests++;
      if (d !== 8'h44) begin n_fail++; $display("FAIL reread_dout: got %h expected 44", d); end
      n_tests++;
      if (rd_cmds - rd0 !== HIT_RDS) begin
         n_fail++;
         $display("FAIL reread_rdcnt: got %0d expected %0d", rd_cmds - rd0, HIT_RDS);
      end
`ifdef GS_DDRAM_CACHE_EN
      n_tests++;
      if (lat !== 1) begin n_fail++; $display("FAIL hit_latency: got %0d expected 1", lat); end
`endif
   endtask

   task automatic test_write_busy();
      logic [7:0] d;
      int lat, p, rc, w0;
      busy_len = 4;
      w0 = we_cycles;
      do_req(1'b1, 1'b1, 22'h000015, 8'hA5, d, lat, p, rc);
      busy_len = 0;
      n_tests++;
      if (we_cycles - w0 !== 5) begin n_fail++; $display("FAIL we_cycles: got %0d expected 5", we_cycles - w0); end
      n_tests++;
      if (last_be !== 8'h20 || last_din !== 64'hA5A5A5A5A5A5A5A5 || last_addr !== 29'h0300002) begin
         n_fail++;
         $display("FAIL wr_cmd: be=%h din=%h addr=%h expected 20 a5a5a5a5a5a5a5a5 0300002", last_be, last_din, last_addr);
      end
      n_tests++;
      if (rc - last_we_cyc !== 2) begin
         n_fail++;
         $display("FAIL wr_ready_timing: ready %0d cycles after last WE, expected 2", rc - last_we_cyc);
      end
      n_tests++;
      if (p !== 1) begin n_fail++; $display("FAIL wr_pulse: got %0d pulses expected 1", p); end
   endtask

   task automatic test_coherency();
      logic [7:0] d;
      int lat, p, rc, rd0;
      do_req(1'b1, 1'b1, 22'h000012, 8'h5A, d, lat, p, rc);
      rd0 = rd_cmds;
      do_req(1'b0, 1'b0, 22'h000012, 8'h00, d, lat, p, rc);
      n_tests++;
      if (d !== 8'h5A) begin n_fail++; $display("FAIL coh_dout: got %h expected 5a", d); end
      n_tests++;
      if (rd_cmds - rd0 !== HIT_RDS) begin
         n_fail++;
         $display("FAIL coh_rdcnt: got %0d expected %0d", rd_cmds - rd0, HIT_RDS);
      end
      do_req(1'b0, 1'b0, 22'h000015, 8'h00, d, lat, p, rc);
      n_tests++;
      if (d !== 8'hA5) begin n_fail++; $display("FAIL coh_earlier_wr: got %h expected a5", d); end
   endtask

   task automatic test_round_robin();
      logic [7:0] d;
      int lat, p, rc, base, t;
      bit a_done, b_done;
      logic [28:0] exp_w;
      do_reset();
      do_req(1'b0, 1'b1, 22'h0000F8, 8'h01, d, lat, p, rc);
      base = cmd_log.size();
      for (int i = 0; i < 4; i++) begin
         a_addr = 22'h000100 + 22'(i * 16);
         b_addr = 22'h000108 + 22'(i * 16);
         a_din = 8'h10 + 8'(i);
         b_din = 8'h20 + 8'(i);
         a_wr = 1'b1;
         b_wr = 1'b1;
         a_done = 0; b_done = 0; t = 0;
         while (!(a_done && b_done) && t < 100) begin
            tick();
            t++;
            if (a_ready) begin a_done = 1; a_wr = 1'b0; end
            if (b_ready) begin b_done = 1; b_wr = 1'b0; end
         end
         a_wr = 1'b0; b_wr = 1'b0;
         n_tests++;
         if (!(a_done && b_done)) begin
            n_fail++;
            $display("FAIL rr_starve_%0d: a_done=%0d b_done=%0d expected 1 1", i, a_done, b_done);
         end
         tick();
      end
      for (int k = 0; k < 8; k++) begin
         exp_w = 29'h0300020 + 29'(k);
         n_tests++;
         if (base + k >= cmd_log.size()) begin
            n_fail++;
            $display("FAIL rr_order_%0d: missing command expected %h", k, exp_w);
         end else if (cmd_log[base + k] !== exp_w) begin
            n_fail++;
            $display("FAIL rr_order_%0d: got %h expected %h", k, cmd_log[base + k], exp_w);
         end
      end
   endtask

   task automatic test_reset_mid_read();
      logic [7:0] d;
      int lat, p, rc, rd0, t, seen;
      rd0 = rd_cmds;
      a_addr = 22'h000040;
      a_rd = 1'b1;
      t = 0;
      while (rd_cmds == rd0 && t < 50) begin tick(); t++; end
      n_tests++;
      if (rd_cmds == rd0) begin n_fail++; $display("FAIL midrd_issue: no read command, expected 1"); end
      tick();
      reset_n = 1'b0;
      a_rd = 1'b0;
      #1;
      n_tests++;
      if ({DDRAM_RD, DDRAM_WE, a_ready, b_ready} !== 4'b0000 || DDRAM_ADDR !== 29'h0 ||
          DDRAM_BE !== 8'h00 || DDRAM_DIN !== 64'h0 || a_dout !== 8'h00) begin
         n_fail++;
         $display("FAIL midrd_reset_vals: rd=%b we=%b ardy=%b addr=%h be=%h dout=%h expected zeros",
                  DDRAM_RD, DDRAM_WE, a_ready, DDRAM_ADDR, DDRAM_BE, a_dout);
      end
      tick();
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (a_ready || b_ready) seen++;
      end
      n_tests++;
      if (seen !== 0 || a_dout !== 8'h00) begin
         n_fail++;
         $display("FAIL midrd_stale: ready cycles=%0d dout=%h expected 0 00", seen, a_dout);
      end
      rd0 = rd_cmds;
      do_req(1'b0, 1'b0, 22'h000040, 8'h00, d, lat, p, rc);
      n_tests++;
      if (rd_cmds - rd0 !== 1 || d !== 8'h08) begin
         n_fail++;
         $display("FAIL midrd_remiss: rdcmds=%0d dout=%h expected 1 08", rd_cmds - rd0, d);
      end
   endtask

   task automatic test_back_to_back_reads();
      logic [7:0] d1, d2;
      int lat, p, rc, rd0;
      rd0 = rd_cmds;
      do_req(1'b1, 1'b0, 22'h000200, 8'h00, d1, lat, p, rc);
      do_req(1'b1, 1'b0, 22'h000200, 8'h00, d2, lat, p, rc);
      n_tests++;
      if (d1 !== 8'h40 || d2 !== 8'h40) begin
         n_fail++;
         $display("FAIL b2b_dout: got %h %h expected 40 40", d1, d2);
      end
      n_tests++;
      if (rd_cmds - rd0 !== 1 + HIT_RDS) begin
         n_fail++;
         $display("FAIL b2b_rdcnt: got %0d expected %0d", rd_cmds - rd0, 1 + HIT_RDS);
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      test_reset();
      test_read_miss();
      test_write_busy();
      test_coherency();
      test_round_robin();
      test_reset_mid_read();
      test_back_to_back_reads();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
